tdc_offset_cal: RTL and testbench

Digital offset-calibration controller for the PLL's signed time-to-digital converter. It sits between the TDC output and the digital loop filter.

- In normal operation it subtracts a stored offset from every TDC sample and saturates the result.
- On request it runs a calibration sequence with the loop held at zero phase error, and converges the stored offset.
- Each calibration iteration discards settling samples, averages a block of corrected samples, and adds the rounded mean to the offset.

---
 rtl/tdc_cal_pkg.sv | 24 ++
 rtl/tdc_offset_cal_corr.sv | 28 ++
 rtl/tdc_offset_cal.sv | 109 ++++++++++
 tb/tb_tdc_offset_cal.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/tdc_cal_pkg.sv
// tdc_cal_pkg: calibration FSM states and width-parameterized saturating arithmetic
package tdc_cal_pkg;

   typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, UPDATE} tdc_cal_state_t;

   // IW must be wide enough that a+b / a-b never wraps before saturation to W bits
   virtual class sat_fn #(parameter int W = 4, parameter int IW = 8);
      static function logic signed [W-1:0] sat(input logic signed [IW-1:0] x);
         logic signed [IW-1:0] hi, lo;
         hi = {{(IW-W+1){1'b0}}, {(W-1){1'b1}}};
         lo = ~hi;
         return (x > hi) ? hi[W-1:0] : (x < lo) ? lo[W-1:0] : x[W-1:0];
      endfunction

      static function logic signed [W-1:0] sat_add(input logic signed [IW-1:0] a, input logic signed [IW-1:0] b);
         return sat(a + b);
      endfunction

      static function logic signed [W-1:0] sat_sub(input logic signed [IW-1:0] a, input logic signed [IW-1:0] b);
         return sat(a - b);
      endfunction
   endclass

endpackage

// File: rtl/tdc_offset_cal_corr.sv
// tdc_corr_sat: subtracts the stored offset from each TDC code, saturates, and registers valid samples
module tdc_corr_sat import tdc_cal_pkg::*; #(
   parameter int NBIT  = 4,
   parameter int OFS_W = 6
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic signed [NBIT-1:0]  tdc_in,
   input  logic                    tdc_valid,
   input  logic signed [OFS_W-1:0] offset,
   output logic signed [NBIT-1:0]  corr_c,
   output logic signed [NBIT-1:0]  tdc_corr,
   output logic                    corr_valid
);
   localparam int IW = NBIT + OFS_W + 1;

   assign corr_c = sat_fn#(NBIT, IW)::sat_sub(IW'(tdc_in), IW'(offset));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tdc_corr   <= '0;
         corr_valid <= 1'b0;
      end else begin
         corr_valid <= tdc_valid;
         if (tdc_valid) tdc_corr <= corr_c;
      end
   end
endmodule

// File: rtl/tdc_offset_cal.sv
// tdc_offset_cal: TDC offset correction with an iterative block-average calibration loop
module tdc_offset_cal import tdc_cal_pkg::*; #(
   parameter int NBIT       = 4,
   parameter int LOG2N      = 4,
   parameter int SETTLE_CYC = 8,
   parameter int MAX_ITER   = 8,
   parameter int OFS_W      = 6
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic signed [NBIT-1:0]  tdc_in,
   input  logic                    tdc_valid,
   input  logic                    cal_start,
   output logic signed [NBIT-1:0]  tdc_corr,
   output logic                    corr_valid,
   output logic signed [OFS_W-1:0] offset,
   output logic                    cal_busy,
   output logic                    cal_done,
   output logic                    cal_fail
);
   localparam int AW  = NBIT + LOG2N;
   localparam int NS  = 2 ** LOG2N;
   localparam int CW  = $clog2(((SETTLE_CYC > NS) ? SETTLE_CYC : NS) + 1);
   localparam int ITW = $clog2(MAX_ITER + 1);
   localparam int UW  = OFS_W + AW + 1;
   localparam logic signed [AW:0] HALF = (AW+1)'(NS / 2);
   localparam tdc_cal_state_t FIRST = (SETTLE_CYC == 0) ? ACCUM : SETTLE;

   tdc_cal_state_t          state, state_n;
   logic signed [NBIT-1:0]  corr_c;
   logic signed [AW-1:0]    acc, acc_n;
   logic signed [AW:0]      mean;
   logic [CW-1:0]           cnt, cnt_n;
   logic [ITW-1:0]          iter, iter_n;
   logic signed [OFS_W-1:0] offset_n;
   logic                    done_n, fail_n, last_settle, last_acc;

   tdc_corr_sat #(.NBIT(NBIT), .OFS_W(OFS_W)) u_corr (
      .clk(clk), .rstn(rstn), .tdc_in(tdc_in), .tdc_valid(tdc_valid), .offset(offset),
      .corr_c(corr_c), .tdc_corr(tdc_corr), .corr_valid(corr_valid)
   );

   // one extra bit so the rounding constant cannot overflow the block sum
   assign mean        = ($signed({acc[AW-1], acc}) + HALF) >>> LOG2N;
   assign last_settle = cnt == CW'(SETTLE_CYC - 1);
   assign last_acc    = cnt == CW'(NS - 1);
   assign cal_busy    = state != IDLE;

   always_comb begin
      state_n  = state;
      acc_n    = acc;
      cnt_n    = cnt;
      iter_n   = iter;
      offset_n = offset;
      done_n   = cal_done;
      fail_n   = cal_fail;
      case (state)
         IDLE: if (cal_start) begin
            done_n  = 1'b0;
            fail_n  = 1'b0;
            iter_n  = '0;
            cnt_n   = '0;
            acc_n   = '0;
            state_n = FIRST;
         end
         SETTLE: if (tdc_valid) begin
            cnt_n   = last_settle ? '0 : cnt + CW'(1);
            acc_n   = last_settle ? '0 : acc;
            state_n = last_settle ? ACCUM : SETTLE;
         end
         ACCUM: if (tdc_valid) begin
            acc_n   = acc + AW'(corr_c);
            cnt_n   = last_acc ? '0 : cnt + CW'(1);
            state_n = last_acc ? UPDATE : ACCUM;
         end
         UPDATE: if (mean == '0) begin
            done_n  = 1'b1;
            state_n = IDLE;
         end else begin
            offset_n = sat_fn#(OFS_W, UW)::sat_add(UW'(offset), UW'(mean));
            iter_n   = iter + ITW'(1);
            fail_n   = iter == ITW'(MAX_ITER - 1);
            acc_n    = '0;
            state_n  = (iter == ITW'(MAX_ITER - 1)) ? IDLE : FIRST;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         acc      <= '0;
         cnt      <= '0;
         iter     <= '0;
         offset   <= '0;
         cal_done <= 1'b0;
         cal_fail <= 1'b0;
      end else begin
         state    <= state_n;
         acc      <= acc_n;
         cnt      <= cnt_n;
         iter     <= iter_n;
         offset   <= offset_n;
         cal_done <= done_n;
         cal_fail <= fail_n;
      end
   end
endmodule

// File: tb/tb_tdc_offset_cal.sv
// tb_tdc_offset_cal: directed and randomized checks of tdc_offset_cal against a block-average reference model
module tb_tdc_offset_cal;
   localparam int NBIT = 4, LOG2N = 4, SETTLE = 8, OFS_W = 6;

   logic clk = 1'b0;
   logic rstn, tdc_valid, cal_start, cal_start2;
   logic signed [NBIT-1:0]  tdc_in;
   logic signed [NBIT-1:0]  corr_a, corr_b;
   logic signed [OFS_W-1:0] ofs_a, ofs_b;
   logic cv_a, cv_b, busy_a, busy_b, done_a, done_b, fail_a, fail_b;

   int n_assert = 0, n_fail = 0;
   int m_ofs[2];
   int last_corr = 0;
   int len;

   always #5 clk = ~clk;

   tdc_offset_cal u_main (
      .clk(clk), .rstn(rstn), .tdc_in(tdc_in), .tdc_valid(tdc_valid), .cal_start(cal_start),
      .tdc_corr(corr_a), .corr_valid(cv_a), .offset(ofs_a), .cal_busy(busy_a),
      .cal_done(done_a), .cal_fail(fail_a)
   );

   tdc_offset_cal #(.MAX_ITER(1)) u_fail (
      .clk(clk), .rstn(rstn), .tdc_in(tdc_in), .tdc_valid(tdc_valid), .cal_start(cal_start2),
      .tdc_corr(corr_b), .corr_valid(cv_b), .offset(ofs_b), .cal_busy(busy_b),
      .cal_done(done_b), .cal_fail(fail_b)
   );

   function automatic int clamp(input int v, input int lo, input int hi);
      return (v > hi) ? hi : (v < lo) ? lo : v;
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Walks the recorded per-edge stimulus: index 0 is the start edge, then each
   // iteration drops SETTLE valid samples, averages the next 2^LOG2N, and spends one update edge.
   function automatic void predict(input int xs[$], input bit vs[$], input int ofs0, input int maxit,
                                   output int e_end, output int e_ofs, output bit e_done, output bit e_fail);
      int i, it, sum, n, mean;
      e_end = -1; e_ofs = ofs0; e_done = 0; e_fail = 0; i = 1; it = 0;
      while (i < xs.size()) begin
         n = 0;
         while (n < SETTLE && i < xs.size()) begin n += int'(vs[i]); i++; end
         n = 0; sum = 0;
         while (n < 2**LOG2N && i < xs.size()) begin
            if (vs[i]) begin sum += clamp(xs[i] - e_ofs, -8, 7); n++; end
            i++;
         end
         if (i >= xs.size()) return;
         mean = (sum + 2**(LOG2N-1)) >>> LOG2N;
         if (mean == 0) begin e_done = 1; e_end = i; return; end
         e_ofs = clamp(e_ofs + mean, -32, 31);
         it++;
         if (it == maxit) begin e_fail = 1; e_end = i; return; end
         i++;
      end
   endfunction

   // xmode: 0 constant c, 1 alternating c/c+1, 2 random c or c+1
   // vmode: 0 always valid, 1 valid on even edges, 2 random ~75% valid
   task automatic calibrate(input bit sel, input int c, input int xmode, input int vmode,
                            input bit restart, output int n);
      int xs[$];
      bit vs[$];
      int x, e_end, e_ofs;
      bit v, busy, e_done, e_fail;
      n = 0;
      forever begin
         x = (xmode == 0) ? c : (xmode == 1) ? c + (n % 2) : c + int'($urandom_range(0, 1));
         x = clamp(x, -8, 7);
         v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (n % 2 == 0) : (n == 0 || $urandom_range(0, 3) != 0);
         tdc_in = NBIT'(x);
         tdc_valid = v;
         xs.push_back(x);
         vs.push_back(v);
         cal_start  = !sel && (n == 0 || (restart && n == 10));
         cal_start2 =  sel && (n == 0 || (restart && n == 10));
         tick();
         busy = sel ? busy_b : busy_a;
         if (n == 0) chk("busy_rise", int'(busy), 1);
         else if (!busy || n >= 1500) break;
         n++;
      end
      cal_start = 1'b0;
      cal_start2 = 1'b0;
      predict(xs, vs, m_ofs[sel], sel ? 1 : 8, e_end, e_ofs, e_done, e_fail);
      chk("cal_len", n, e_end);
      chk("cal_offset", sel ? int'(ofs_b) : int'(ofs_a), e_ofs);
      chk("cal_done", int'(sel ? done_b : done_a), int'(e_done));
      chk("cal_fail", int'(sel ? fail_b : fail_a), int'(e_fail));
      m_ofs[sel] = e_ofs;
   endtask

   task automatic datapath(input int cycles);
      int x;
      bit v;
      for (int i = 0; i < cycles; i++) begin
         x = int'($urandom_range(0, 15)) - 8;
         v = (i == 0) || ($urandom_range(0, 2) != 0);
         tdc_in = NBIT'(x);
         tdc_valid = v;
         tick();
         if (v) last_corr = clamp(x - m_ofs[0], -8, 7);
         chk("corr", int'(corr_a), last_corr);
         chk("corr_valid", int'(cv_a), int'(v));
      end
   endtask

   initial begin
      rstn = 1'b1; tdc_in = '0; tdc_valid = 1'b0; cal_start = 1'b0; cal_start2 = 1'b0;
      m_ofs[0] = 0; m_ofs[1] = 0;
      #2 rstn = 1'b0;
      #2;
      chk("rst_offset", int'(ofs_a), 0);
      chk("rst_corr", int'(corr_a), 0);
      chk("rst_cv", int'(cv_a), 0);
      chk("rst_busy", int'(busy_a), 0);
      chk("rst_done", int'(done_a), 0);
      chk("rst_fail", int'(fail_a), 0);
      chk("rst_offset_b", int'(ofs_b), 0);
      chk("rst_busy_b", int'(busy_b), 0);
      @(negedge clk) rstn = 1'b1;
      tick();

      datapath(20);

      calibrate(0, 3, 0, 0, 0, len);
      chk("conv_len", len, 50);
      chk("conv_offset", int'(ofs_a), 3);
      chk("conv_done", int'(done_a), 1);
      chk("conv_corr", int'(corr_a), 0);
      chk("conv_cv", int'(cv_a), 1);

      tdc_in = -4'sd8; tdc_valid = 1'b1; tick();
      chk("sat_low", int'(corr_a), -8);
      tdc_in = 4'sd7; tick();
      chk("sat_high", int'(corr_a), 4);
      last_corr = 4;
      datapath(20);

      tdc_in = '0; tdc_valid = 1'b1; cal_start = 1'b1; tick();
      cal_start = 1'b0;
      repeat (14) tick();
      chk("accum_busy", int'(busy_a), 1);
      chk("accum_offset", int'(ofs_a), 3);
      #2 rstn = 1'b0;
      #1;
      chk("arst_offset", int'(ofs_a), 0);
      chk("arst_busy", int'(busy_a), 0);
      chk("arst_done", int'(done_a), 0);
      chk("arst_fail", int'(fail_a), 0);
      chk("arst_corr", int'(corr_a), 0);
      chk("arst_cv", int'(cv_a), 0);
      @(negedge clk) rstn = 1'b1;
      m_ofs[0] = 0; m_ofs[1] = 0;
      repeat (30) begin
         tick();
         chk("idle_busy", int'(busy_a), 0);
      end
      chk("idle_offset", int'(ofs_a), 0);

      calibrate(0, 2, 0, 1, 1, len);
      chk("gap_len", len, 97);
      chk("gap_offset", int'(ofs_a), 2);
      chk("gap_done", int'(done_a), 1);

      rstn = 1'b0; tick(); rstn = 1'b1; tick();
      m_ofs[0] = 0; m_ofs[1] = 0;
      calibrate(0, 0, 1, 0, 0, len);
      chk("round_len", len, 50);
      chk("round_offset", int'(ofs_a), 1);
      chk("round_done", int'(done_a), 1);

      calibrate(1, -5, 0, 0, 0, len);
      chk("fail_len", len, 25);
      chk("fail_offset", int'(ofs_b), -5);
      chk("fail_flag", int'(fail_b), 1);
      chk("fail_done", int'(done_b), 0);
      chk("fail_busy", int'(busy_b), 0);

      repeat (6) begin
         calibrate(0, int'($urandom_range(0, 12)) - 6, 2, 2, 0, len);
         datapath(8);
      end
      calibrate(1, int'($urandom_range(0, 12)) - 6, 2, 2, 0, len);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
